// File: rtl/mcs4_ram_master.sv
// MCS-4 RAM bus initiator: emits 8-phase sync framing and SRC / RAM I/O frames for host commands.
// Latency: accept in X3; response in X3 8 cycles later (cache hit) or 16 cycles later (SRC issued).
// Backpressure: cmd_ready is a registered one-cycle window in X3 of an IDLE or finishing IO frame.
module mcs4_ram_master #(
  parameter bit SRC_CACHE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sync,
  output logic       cm_ram,
  output logic [3:0] dbus_out,
  output logic       dbus_oe,
  input  logic [3:0] dbus_in,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_opa,
  input  logic [7:0] cmd_addr,
  input  logic [3:0] cmd_wdata,
  input  logic       cmd_force_src,
  output logic       rsp_valid,
  output logic [3:0] rsp_rdata,
  output logic       rsp_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SRC, ST_IO} state_t;

  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [3:0]  opa_q, wdata_q, rd_q, rd_d;
  logic [7:0]  addr_q, last_addr_q;
  logic        last_valid_q;
  logic        accept, opa_err, src_need, rd_op;
  logic [3:0]  dat_d;
  logic        oe_d, cm_d;

  // Next phase/state, command classification and next bus drive values.
  always_comb begin
    phase_d  = phase_q + 3'd1;
    accept   = cmd_valid && cmd_ready;
    opa_err  = (cmd_opa == 4'h2) || (cmd_opa == 4'h3) || (cmd_opa == 4'hA);
    src_need = cmd_force_src || !SRC_CACHE || !last_valid_q || (cmd_addr != last_addr_q);
    // Unsupported OPAs never reach the IO state, so bit 3 alone marks a read here.
    rd_op    = opa_q[3];

    state_d = state_q;
    if (phase_q == PH_X3) begin
      case (state_q)
        ST_SRC:  state_d = ST_IO;
        default: begin
          if (accept && !opa_err) state_d = src_need ? ST_SRC : ST_IO;
          else                    state_d = ST_IDLE;
        end
      endcase
    end

    rd_d = rd_q;
    if (state_q == ST_IO && phase_q == PH_X2 && rd_op) rd_d = dbus_in;

    // Drive values for the phase being entered; phases 3..7 never cross a state change.
    dat_d = 4'h0;
    oe_d  = 1'b1;
    cm_d  = 1'b0;
    case (phase_d)
      PH_M1: begin
        if (state_q == ST_SRC)     dat_d = 4'h2;
        else if (state_q == ST_IO) dat_d = 4'hE;
      end
      PH_M2: begin
        if (state_q == ST_SRC) dat_d = 4'h1;
        else if (state_q == ST_IO) begin
          dat_d = opa_q;
          cm_d  = 1'b1;
        end
      end
      PH_X2: begin
        if (state_q == ST_SRC) begin
          dat_d = addr_q[7:4];
          cm_d  = 1'b1;
        end else if (state_q == ST_IO) begin
          if (rd_op) oe_d  = 1'b0;
          else       dat_d = wdata_q;
        end
      end
      PH_X3: begin
        if (state_q == ST_SRC) dat_d = addr_q[3:0];
      end
      default: dat_d = 4'h0;
    endcase
  end

  // Frame sequencer, command/cache registers and registered bus/host outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= 3'd0;
      opa_q        <= 4'h0;
      wdata_q      <= 4'h0;
      addr_q       <= 8'h00;
      last_addr_q  <= 8'h00;
      last_valid_q <= 1'b0;
      rd_q         <= 4'h0;
      sync         <= 1'b0;
      cm_ram       <= 1'b0;
      dbus_out     <= 4'h0;
      dbus_oe      <= 1'b1;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 4'h0;
      rsp_err      <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rd_q    <= rd_d;
      if (accept) begin
        opa_q   <= cmd_opa;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (phase_q == PH_X3 && state_q == ST_SRC) begin
        last_addr_q  <= addr_q;
        last_valid_q <= 1'b1;
      end
      sync      <= (phase_d == PH_X3);
      cmd_ready <= (phase_d == PH_X3) && (state_q != ST_SRC);
      cm_ram    <= cm_d;
      dbus_out  <= dat_d;
      dbus_oe   <= oe_d;
      rsp_valid <= 1'b0;
      if (accept && opa_err) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= 4'h0;
      end else if (state_q == ST_IO && phase_d == PH_X3) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= rd_op ? rd_d : 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_mcs4_ram_master.sv
// Directed bench for mcs4_ram_master: one cached instance, one with the SRC cache disabled.
// A small 4002-style responder decodes instance 0's bus and returns stored nibbles in read X2.
// Observation window obs[i] holds the outputs i cycles after the accepting X3.
module tb_mcs4_ram_master;

  logic       clk, rst;
  logic [3:0] dbus_in;
  logic       cmd_valid0, cmd_valid1, cmd_force_src;
  logic [3:0] cmd_opa, cmd_wdata;
  logic [7:0] cmd_addr;
  logic       sync0, cm0, oe0, rdy0, rv0, err0;
  logic       sync1, cm1, oe1, rdy1, rv1, err1;
  logic [3:0] dout0, rd0, dout1, rd1;

  int errs = 0;
  int checks = 0;

  logic [3:0] o_dat [1:24];
  logic       o_oe [1:24], o_cm [1:24], o_rv [1:24], o_err [1:24], o_sync [1:24];
  logic [3:0] o_rd [1:24];

  mcs4_ram_master #(.SRC_CACHE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .sync(sync0), .cm_ram(cm0), .dbus_out(dout0), .dbus_oe(oe0),
    .dbus_in(dbus_in), .cmd_valid(cmd_valid0), .cmd_ready(rdy0), .cmd_opa(cmd_opa),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_force_src(cmd_force_src),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0)
  );

  mcs4_ram_master #(.SRC_CACHE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .sync(sync1), .cm_ram(cm1), .dbus_out(dout1), .dbus_oe(oe1),
    .dbus_in(dbus_in), .cmd_valid(cmd_valid1), .cmd_ready(rdy1), .cmd_opa(cmd_opa),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_force_src(cmd_force_src),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder model for instance 0: tracks phase, latches SRC address, stores WRM data.
  logic [3:0] mem [0:255];
  logic [2:0] m_ph;
  logic [7:0] m_addr;
  logic [3:0] m_cr, m_op;
  logic       m_io, m_src;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'h0;
    m_addr = 8'h00;
    m_cr   = 4'h0;
    m_op   = 4'hF;
  end

  always @(negedge clk) begin
    if (rst) begin
      m_ph  <= 3'd0;
      m_io  <= 1'b0;
      m_src <= 1'b0;
    end else begin
      m_ph <= m_ph + 3'd1;
      if (m_ph == 3'd6 && cm0) begin m_cr <= dout0; m_src <= 1'b1; end
      if (m_ph == 3'd7 && m_src) begin m_addr <= {m_cr, dout0}; m_src <= 1'b0; end
      if (m_ph == 3'd4 && cm0) begin m_op <= dout0; m_io <= 1'b1; end
      if (m_ph == 3'd6 && m_io && m_op == 4'h0) mem[m_addr] <= dout0;
      if (m_ph == 3'd7) m_io <= 1'b0;
    end
  end

  assign dbus_in = mem[m_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int d, input int n);
    for (int i = 1; i <= n; i++) begin
      o_dat[i]  = d ? dout1 : dout0;
      o_oe[i]   = d ? oe1 : oe0;
      o_cm[i]   = d ? cm1 : cm0;
      o_rv[i]   = d ? rv1 : rv0;
      o_err[i]  = d ? err1 : err0;
      o_rd[i]   = d ? rd1 : rd0;
      o_sync[i] = d ? sync1 : sync0;
      tick;
    end
  endtask

  task automatic issue(input int d, input logic [3:0] opa, input logic [7:0] addr,
                       input logic [3:0] wd, input logic frc);
    int n = 0;
    while (!(d ? rdy1 : rdy0) && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n >= 40) begin errs++; $display("FAIL issue_ready_timeout ready=0 required=1"); end
    cmd_opa       = opa;
    cmd_addr      = addr;
    cmd_wdata     = wd;
    cmd_force_src = frc;
    if (d != 0) cmd_valid1 = 1'b1;
    else        cmd_valid0 = 1'b1;
    tick;
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({sync0, cm0, dout0, oe0, rdy0, rv0, rd0, err0} !== {1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
      errs++;
      $display("FAIL reset_outputs sync=%b cm=%b dat=%h oe=%b rdy=%b rv=%b rd=%h err=%b required 0 0 0 1 0 0 0 0",
               sync0, cm0, dout0, oe0, rdy0, rv0, rd0, err0);
    end
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (sync0 !== (k % 8 == 7)) begin errs++; $display("FAIL idle_sync cycle=%0d sync=%b required=%b", k, sync0, (k % 8 == 7)); end
      checks++;
      if (cm0 !== 1'b0 || dout0 !== 4'h0 || oe0 !== 1'b1) begin
        errs++; $display("FAIL idle_bus cycle=%0d cm=%b dat=%h oe=%b required cm=0 dat=0 oe=1", k, cm0, dout0, oe0);
      end
      if (k < 7) begin
        checks++;
        if (rdy0 !== 1'b0) begin errs++; $display("FAIL early_ready cycle=%0d rdy=%b required=0", k, rdy0); end
      end
      tick;
    end
  endtask

  task automatic test_wrm_cold;
    int ncm = 0, nrv = 0;
    issue(0, 4'h0, 8'h5A, 4'h7, 1'b0);
    capture(0, 16);
    for (int i = 1; i <= 16; i++) begin
      if (o_cm[i] === 1'b1) ncm++;
      if (o_rv[i] === 1'b1) nrv++;
    end
    checks++;
    if (o_dat[4] !== 4'h2 || o_dat[5] !== 4'h1 || o_cm[5] !== 1'b0) begin
      errs++; $display("FAIL wrm_src_opcode m1=%h m2=%h cm=%b required 2 1 0", o_dat[4], o_dat[5], o_cm[5]);
    end
    checks++;
    if (o_dat[7] !== 4'h5 || o_cm[7] !== 1'b1) begin errs++; $display("FAIL wrm_src_x2 dat=%h cm=%b required 5 1", o_dat[7], o_cm[7]); end
    checks++;
    if (o_dat[8] !== 4'hA || o_cm[8] !== 1'b0) begin errs++; $display("FAIL wrm_src_x3 dat=%h cm=%b required a 0", o_dat[8], o_cm[8]); end
    checks++;
    if (o_dat[12] !== 4'hE || o_dat[13] !== 4'h0 || o_cm[13] !== 1'b1) begin
      errs++; $display("FAIL wrm_io_m1m2 m1=%h m2=%h cm=%b required e 0 1", o_dat[12], o_dat[13], o_cm[13]);
    end
    checks++;
    if (o_dat[15] !== 4'h7 || o_oe[15] !== 1'b1 || o_cm[15] !== 1'b0) begin
      errs++; $display("FAIL wrm_io_x2 dat=%h oe=%b cm=%b required 7 1 0", o_dat[15], o_oe[15], o_cm[15]);
    end
    checks++;
    if (o_rv[16] !== 1'b1 || o_err[16] !== 1'b0 || o_rd[16] !== 4'h0 || o_sync[16] !== 1'b1 || nrv != 1) begin
      errs++; $display("FAIL wrm_rsp rv=%b err=%b rd=%h sync=%b pulses=%0d required 1 0 0 1 1", o_rv[16], o_err[16], o_rd[16], o_sync[16], nrv);
    end
    checks++;
    if (ncm != 2) begin errs++; $display("FAIL wrm_cm_count got=%0d required=2", ncm); end
  endtask

  task automatic test_rdm_cache;
    issue(0, 4'h9, 8'h5A, 4'h0, 1'b0);
    capture(0, 8);
    checks++;
    if (o_dat[4] !== 4'hE || o_dat[5] !== 4'h9 || o_cm[5] !== 1'b1) begin
      errs++; $display("FAIL rdm_io_m1m2 m1=%h m2=%h cm=%b required e 9 1", o_dat[4], o_dat[5], o_cm[5]);
    end
    checks++;
    if (o_oe[7] !== 1'b0 || o_dat[7] !== 4'h0 || o_cm[7] !== 1'b0) begin
      errs++; $display("FAIL rdm_x2 oe=%b dat=%h cm=%b required 0 0 0", o_oe[7], o_dat[7], o_cm[7]);
    end
    checks++;
    if (o_rv[8] !== 1'b1 || o_rd[8] !== 4'h7 || o_err[8] !== 1'b0) begin
      errs++; $display("FAIL rdm_rsp rv=%b rd=%h err=%b required 1 7 0", o_rv[8], o_rd[8], o_err[8]);
    end
    checks++;
    if (rd0 !== 4'h7 || rv0 !== 1'b0) begin errs++; $display("FAIL rdm_hold rd=%h rv=%b required 7 0", rd0, rv0); end
  endtask

  task automatic test_force_src;
    issue(0, 4'h4, 8'h5A, 4'h3, 1'b1);
    capture(0, 16);
    checks++;
    if (o_dat[4] !== 4'h2 || o_dat[7] !== 4'h5 || o_cm[7] !== 1'b1 || o_rv[16] !== 1'b1) begin
      errs++; $display("FAIL force_src m1=%h x2=%h cm=%b rv16=%b required 2 5 1 1", o_dat[4], o_dat[7], o_cm[7], o_rv[16]);
    end
    issue(0, 4'h4, 8'h6A, 4'h1, 1'b0);
    capture(0, 16);
    checks++;
    if (o_dat[7] !== 4'h6 || o_dat[8] !== 4'hA || o_dat[12] !== 4'hE || o_dat[13] !== 4'h4 || o_rv[16] !== 1'b1) begin
      errs++; $display("FAIL newaddr_src x2=%h x3=%h io_m1=%h io_m2=%h rv16=%b required 6 a e 4 1",
                       o_dat[7], o_dat[8], o_dat[12], o_dat[13], o_rv[16]);
    end
  endtask

  task automatic test_back_to_back;
    issue(0, 4'h0, 8'h6A, 4'h3, 1'b0);
    capture(0, 7);
    checks++;
    if (rv0 !== 1'b1 || rdy0 !== 1'b1) begin errs++; $display("FAIL b2b_window rv=%b rdy=%b required 1 1", rv0, rdy0); end
    issue(0, 4'h9, 8'h6A, 4'h0, 1'b0);
    capture(0, 8);
    checks++;
    if (o_dat[4] !== 4'hE || o_dat[5] !== 4'h9 || o_rv[8] !== 1'b1 || o_rd[8] !== 4'h3) begin
      errs++; $display("FAIL b2b_second m1=%h m2=%h rv=%b rd=%h required e 9 1 3", o_dat[4], o_dat[5], o_rv[8], o_rd[8]);
    end
  endtask

  task automatic test_unsupported;
    int ncm = 0, nrv = 0;
    issue(0, 4'hA, 8'h5A, 4'h0, 1'b0);
    capture(0, 8);
    for (int i = 1; i <= 8; i++) begin
      if (o_cm[i] === 1'b1) ncm++;
      if (o_rv[i] === 1'b1) nrv++;
    end
    checks++;
    if (o_rv[1] !== 1'b1 || o_err[1] !== 1'b1 || o_rd[1] !== 4'h0) begin
      errs++; $display("FAIL unsup_rsp rv=%b err=%b rd=%h required 1 1 0", o_rv[1], o_err[1], o_rd[1]);
    end
    checks++;
    if (ncm != 0 || nrv != 1 || o_dat[4] !== 4'h0) begin
      errs++; $display("FAIL unsup_nobus cm_pulses=%0d rv_pulses=%0d m1=%h required 0 1 0", ncm, nrv, o_dat[4]);
    end
  endtask

  task automatic test_nocache;
    issue(1, 4'h0, 8'h5A, 4'h1, 1'b0);
    capture(1, 16);
    checks++;
    if (o_dat[7] !== 4'h5 || o_cm[7] !== 1'b1 || o_rv[16] !== 1'b1) begin
      errs++; $display("FAIL nocache_first x2=%h cm=%b rv16=%b required 5 1 1", o_dat[7], o_cm[7], o_rv[16]);
    end
    issue(1, 4'h0, 8'h5A, 4'h2, 1'b0);
    capture(1, 16);
    checks++;
    if (o_dat[4] !== 4'h2 || o_dat[7] !== 4'h5 || o_cm[7] !== 1'b1 || o_dat[15] !== 4'h2 || o_rv[16] !== 1'b1) begin
      errs++; $display("FAIL nocache_repeat m1=%h x2=%h cm=%b io_x2=%h rv16=%b required 2 5 1 2 1",
                       o_dat[4], o_dat[7], o_cm[7], o_dat[15], o_rv[16]);
    end
  endtask

  task automatic test_reset_midframe;
    int nbad = 0;
    issue(0, 4'h0, 8'h5A, 4'h5, 1'b0);
    capture(0, 13);
    checks++;
    if (o_dat[12] !== 4'hE) begin errs++; $display("FAIL mid_in_io io_m1=%h required e", o_dat[12]); end
    do_reset;
    checks++;
    if (cm0 !== 1'b0 || rv0 !== 1'b0 || rdy0 !== 1'b0 || sync0 !== 1'b0) begin
      errs++; $display("FAIL mid_after_reset cm=%b rv=%b rdy=%b sync=%b required 0 0 0 0", cm0, rv0, rdy0, sync0);
    end
    capture(0, 8);
    for (int i = 1; i <= 8; i++) if (o_rv[i] === 1'b1 || o_cm[i] === 1'b1) nbad++;
    checks++;
    if (nbad != 0) begin errs++; $display("FAIL mid_no_rsp stray_cycles=%0d required=0", nbad); end
    issue(0, 4'h6, 8'h5A, 4'h9, 1'b0);
    capture(0, 16);
    checks++;
    if (o_dat[4] !== 4'h2 || o_dat[7] !== 4'h5 || o_cm[7] !== 1'b1 || o_dat[8] !== 4'hA) begin
      errs++; $display("FAIL wr2_src m1=%h x2=%h cm=%b x3=%h required 2 5 1 a", o_dat[4], o_dat[7], o_cm[7], o_dat[8]);
    end
    checks++;
    if (o_dat[13] !== 4'h6 || o_cm[13] !== 1'b1 || o_dat[15] !== 4'h9 || o_rv[16] !== 1'b1 || o_err[16] !== 1'b0) begin
      errs++; $display("FAIL wr2_io m2=%h cm=%b x2=%h rv=%b err=%b required 6 1 9 1 0",
                       o_dat[13], o_cm[13], o_dat[15], o_rv[16], o_err[16]);
    end
  endtask

  initial begin
    rst           = 1'b1;
    cmd_valid0    = 1'b0;
    cmd_valid1    = 1'b0;
    cmd_opa       = 4'h0;
    cmd_addr      = 8'h00;
    cmd_wdata     = 4'h0;
    cmd_force_src = 1'b0;
    test_reset;
    test_wrm_cold;
    test_rdm_cache;
    test_force_src;
    test_back_to_back;
    test_unsupported;
    test_nocache;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mcs4_ram_master.md
# mcs4_ram_master

Bus initiator for the MCS-4 RAM interface. It generates the 8-phase instruction-cycle framing (`sync`) on the shared 4-bit data bus and issues SRC and RAM I/O instruction frames to the 4002 RAM responders. Commands arrive one at a time from a host-side valid/ready port, and each completion is reported with a response pulse. It sits on the PYNQ side and stands in for the 4004 CPU when the host accesses RAM/status/output ports directly.

## Interface
- `SRC_CACHE`, default 1: when 1, the SRC frame is skipped if the command address matches the last address sent by SRC.
- `clk` in 1: clock; one bus phase per cycle.
- `rst` in 1: reset, synchronous, active-high.
- `sync` out 1: frame marker, high during the X3 phase.
- `cm_ram` out 1: RAM command strobe.
- `dbus_out` out 4: data driven onto the bus.
- `dbus_oe` out 1: `dbus_out` is valid/driven.
- `dbus_in` in 4: bus data from the responders, read in X2.
- `cmd_valid` in 1: host command present.
- `cmd_ready` out 1: command accepted on `cmd_valid && cmd_ready`.
- `cmd_opa` in 4: I/O OPA (WRM=0, WMP=1, WR0..3=4..7, SBM=8, RDM=9, ADM=B, RD0..3=C..F).
- `cmd_addr` in 8: {chip[1:0], reg[1:0], char[3:0]}.
- `cmd_wdata` in 4: write data.
- `cmd_force_src` in 1: emit SRC regardless of the cache.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 4: read data (0 for write ops).
- `rsp_err` out 1: unsupported OPA (2, 3, A); no bus I/O performed.

## Operation
- Phase counter cycles A1,A2,A3,M1,M2,X1,X2,X3 (0..7) continuously, one phase per clk, and wraps X3->A1. `sync` is 1 exactly in X3, so responders see phase 0 on the following cycle.
- States: IDLE, SRC, IO. The state changes only at the X3->A1 boundary.
- Frame contents (`dbus_oe` = 1 in every phase except X2 of an IO read):
  - A1..A3: drive 0.
  - IDLE frame: M1=0, M2=0 (NOP); `cm_ram`=0 throughout.
  - SRC frame: M1=0x2, M2=0x1, `cm_ram`=0 in M2. X2 drives {chip,reg} with `cm_ram`=1. X3 drives char with `cm_ram`=0. After the frame, `last_addr` <= `cmd_addr` and `last_valid` <= 1.
  - IO frame: M1=0xE, M2=`cmd_opa` with `cm_ram`=1.
    - Write ops (0,1,4..7): X2 drives `cmd_wdata`, `cm_ram`=0.
    - Read ops (8,9,B,C..F): X2 `dbus_oe`=0, `dbus_out`=0, `cm_ram`=0; `dbus_in` is captured into the read register at the end of X2.
    - X1 and X3 drive 0.
- Command capture: all command fields are registered on accept and are stable until `rsp_valid`.
- Next state from IDLE on accept:
  - Unsupported OPA: stays IDLE. `rsp_valid`=1 with `rsp_err`=1 on the cycle after accept (A1); no SRC or IO frame is emitted.
  - SRC needed (`cmd_force_src`, or `SRC_CACHE`=0, or `!last_valid`, or `addr != last_addr`): next state is SRC, then IO.
  - Otherwise: next state is IO.
- After the IO frame, state returns to IDLE unless a new command is accepted in that same X3.
- `cm_ram` is never 1 outside M2 of IO or X2 of SRC.

## Timing
- Reset: phase=A1, state=IDLE, `last_valid`=0, read register=0. Outputs `sync`=0, `cm_ram`=0, `dbus_out`=0, `dbus_oe`=1, `cmd_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- The first frame after reset is IDLE. `cmd_ready` stays 0 until the first `sync` has been emitted (cycle 7 after reset release).
- `cmd_ready` = 1 only in X3 when the state is IDLE or ending IO. It does not depend combinationally on `cmd_valid`.
- Latency, accept at X3 cycle t:
  - No SRC: IO frame occupies t+1..t+8; `rsp_valid` in X3 at t+8.
  - With SRC: SRC frame t+1..t+8, IO frame t+9..t+16; `rsp_valid` at t+16.
- `rsp_valid` coincides with `sync` for completed IO frames. `rsp_rdata` is held until the next `rsp_valid`.
- Back-to-back commands: a new accept is allowed in the same X3 as `rsp_valid`, giving 8-cycle throughput with cache hits.
- Reset mid-frame: the frame is aborted and the command dropped, with no `rsp_valid`. `last_valid` is cleared, so the next command issues SRC.

## Test plan
- Reset, then idle 24 cycles: `sync` high at cycles 7, 15, 23; `cm_ram` always 0; bus shows only 0 nibbles.
- WRM to addr 0x5A with data 0x7, cold cache:
  - SRC frame: X2 drives 0x5 with `cm_ram`=1, X3 drives 0xA.
  - IO frame: M2 drives 0x0 with `cm_ram`=1, X2 drives 0x7.
  - `rsp_valid` 16 cycles after accept with `rsp_err`=0.
- RDM to 0x5A right after: SRC is skipped. X2 has `dbus_oe`=0; the responder model returns 0x7; `rsp_rdata`=0x7 at 8 cycles after accept.
- Same address with `cmd_force_src`=1, then addr 0x6A: both emit SRC. Repeat with `SRC_CACHE`=0: SRC is emitted for every command.
- OPA=0xA: `rsp_err`=1 and `rsp_valid` on the next cycle; no `cm_ram` pulse occurs.
- Assert `rst` at X1 of an IO write: no `rsp_valid`, `cm_ram`=0 after reset. The next WR2 to 0x5A emits SRC, and X2 carries the write data.
